// File: rtl/trdb_packet_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : trdb_packet_scheduler
// Brief    : Packet FIFO between priority and encapsulator; owns resync logic.
// Revision : 1.0
// ============================================================================
module trdb_packet_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int PAYLOAD_W  = 64,
    parameter int RESYNC_MAX = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 pkt_valid_i,
    input  logic [1:0]           packet_format_i,
    input  logic [1:0]           packet_f_sync_subformat_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    input  logic                 resync_rst_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [1:0]           out_format_o,
    output logic [1:0]           out_subformat_o,
    output logic [PAYLOAD_W-1:0] out_payload_o,
    output logic                 max_resync_o,
    output logic                 drop_o,
    output logic [15:0]          drop_cnt_o,
    output logic                 busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = $clog2(RESYNC_MAX + 1);
    localparam logic [RW-1:0] C_RCNT_MAX = RW'(RESYNC_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [AW:0]           wptr_q, wptr_d;
    logic [AW:0]           rptr_q, rptr_d;
    logic [1:0]            fmt_mem_q [FIFO_DEPTH];
    logic [1:0]            fmt_mem_d [FIFO_DEPTH];
    logic [1:0]            sub_mem_q [FIFO_DEPTH];
    logic [1:0]            sub_mem_d [FIFO_DEPTH];
    logic [PAYLOAD_W-1:0]  pay_mem_q [FIFO_DEPTH];
    logic [PAYLOAD_W-1:0]  pay_mem_d [FIFO_DEPTH];
    logic [RW-1:0]         rcnt_q, rcnt_d;
    logic                  force_sync_q, force_sync_d;
    logic                  drop_q, drop_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  is_sync;
    logic                  accept;
    logic                  drop;

    // Extra MSB on each pointer separates full (MSBs differ) from empty.
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop     = out_valid_o && out_ready_i;
    assign is_sync = (packet_format_i == 2'd3) && (packet_f_sync_subformat_i == 2'd0);
    assign accept  = (state_q == ST_RUN) && pkt_valid_i && (!full || pop);
    assign drop    = (state_q == ST_RUN) && pkt_valid_i && full && !pop;

    always_comb begin
        state_d      = state_q;
        force_sync_d = force_sync_q;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d      = ST_RUN;
                    force_sync_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (enable_i) begin
                    state_d      = ST_RUN;
                    force_sync_d = 1'b1;
                end else if (empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Accept and drop are exclusive, so these never contend.
        if (drop) begin
            force_sync_d = 1'b1;
        end
        if (accept && is_sync) begin
            force_sync_d = 1'b0;
        end
    end

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        fmt_mem_d = fmt_mem_q;
        sub_mem_d = sub_mem_q;
        pay_mem_d = pay_mem_q;
        if (accept) begin
            fmt_mem_d[wptr_q[AW-1:0]] = packet_format_i;
            sub_mem_d[wptr_q[AW-1:0]] = packet_f_sync_subformat_i;
            pay_mem_d[wptr_q[AW-1:0]] = payload_i;
            wptr_d                    = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_comb begin
        rcnt_d     = rcnt_q;
        drop_d     = drop;
        drop_cnt_d = drop_cnt_q;
        if ((accept && is_sync) || resync_rst_i) begin
            rcnt_d = '0;
        end else if (accept && (rcnt_q != C_RCNT_MAX)) begin
            rcnt_d = rcnt_q + 1'b1;
        end
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            wptr_q       <= '0;
            rptr_q       <= '0;
            fmt_mem_q    <= '{default: '0};
            sub_mem_q    <= '{default: '0};
            pay_mem_q    <= '{default: '0};
            rcnt_q       <= '0;
            force_sync_q <= 1'b0;
            drop_q       <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            fmt_mem_q    <= fmt_mem_d;
            sub_mem_q    <= sub_mem_d;
            pay_mem_q    <= pay_mem_d;
            rcnt_q       <= rcnt_d;
            force_sync_q <= force_sync_d;
            drop_q       <= drop_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Head fields are forced to zero while empty so stale slots never leak.
    assign out_valid_o     = !empty;
    assign out_format_o    = empty ? 2'd0 : fmt_mem_q[rptr_q[AW-1:0]];
    assign out_subformat_o = empty ? 2'd0 : sub_mem_q[rptr_q[AW-1:0]];
    assign out_payload_o   = empty ? '0   : pay_mem_q[rptr_q[AW-1:0]];
    assign max_resync_o    = (rcnt_q == C_RCNT_MAX) || force_sync_q;
    assign drop_o          = drop_q;
    assign drop_cnt_o      = drop_cnt_q;
    assign busy_o          = !empty || (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_trdb_packet_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_trdb_packet_scheduler
// Brief    : Directed vector table plus corner sequences for the scheduler.
// Revision : 1.0
// ============================================================================
module tb_trdb_packet_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        vld;
    logic [1:0]  fmt;
    logic [1:0]  sub;
    logic [63:0] pay;
    logic        rrst;
    logic        rdy;
    logic        ov;
    logic [1:0]  of;
    logic [1:0]  os;
    logic [63:0] op;
    logic        mr;
    logic        drp;
    logic [15:0] dcnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trdb_packet_scheduler #(
        .FIFO_DEPTH(4),
        .PAYLOAD_W (64),
        .RESYNC_MAX(16)
    ) dut (
        .clk_i                    (clk),
        .rst_i                    (rst),
        .enable_i                 (en),
        .pkt_valid_i              (vld),
        .packet_format_i          (fmt),
        .packet_f_sync_subformat_i(sub),
        .payload_i                (pay),
        .resync_rst_i             (rrst),
        .out_valid_o              (ov),
        .out_ready_i              (rdy),
        .out_format_o             (of),
        .out_subformat_o          (os),
        .out_payload_o            (op),
        .max_resync_o             (mr),
        .drop_o                   (drp),
        .drop_cnt_o               (dcnt),
        .busy_o                   (busy)
    );

    typedef struct {
        logic        rst, en, vld;
        logic [1:0]  fmt, sub;
        logic [63:0] pay;
        logic        rrst, rdy;
        logic        ov;
        logic [1:0]  of, os;
        logic [63:0] op;
        logic        mr, drp;
        logic [15:0] dcnt;
        logic        busy;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] model[$];

    function automatic vec_t mk(
        input logic rst_v, input logic en_v, input logic vld_v,
        input logic [1:0] fmt_v, input logic [1:0] sub_v, input logic [63:0] pay_v,
        input logic rrst_v, input logic rdy_v,
        input logic ov_e, input logic [1:0] of_e, input logic [1:0] os_e,
        input logic [63:0] op_e, input logic mr_e, input logic drp_e,
        input logic [15:0] dcnt_e, input logic busy_e);
        vec_t v;
        v.rst = rst_v;  v.en = en_v;   v.vld = vld_v;
        v.fmt = fmt_v;  v.sub = sub_v; v.pay = pay_v;
        v.rrst = rrst_v; v.rdy = rdy_v;
        v.ov = ov_e;    v.of = of_e;   v.os = os_e;   v.op = op_e;
        v.mr = mr_e;    v.drp = drp_e; v.dcnt = dcnt_e; v.busy = busy_e;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs mid-cycle, then sample one time unit after the next edge.
    task automatic step(input logic r, input logic e, input logic v, input logic [1:0] f,
                        input logic [1:0] s, input logic [63:0] p, input logic rr,
                        input logic rd);
        rst = r; en = e; vld = v; fmt = f; sub = s; pay = p; rrst = rr; rdy = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; vld = 1'b0; fmt = '0; sub = '0; pay = '0;
        rrst = 1'b0; rdy = 1'b0;

        //            rst en vld fmt sub pay    rr rdy | ov of os op     mr dr dcnt busy
        vecs.push_back(mk(1, 0, 0, 0, 0, 64'h0,  0, 0,   0, 0, 0, 64'h0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 64'h0,  0, 0,   0, 0, 0, 64'h0,  1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 3, 0, 64'hA5, 0, 0,   1, 3, 0, 64'hA5, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 2, 0, 64'h11, 0, 1,   1, 2, 0, 64'h11, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 64'h0,  0, 0,   1, 2, 0, 64'h11, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 64'h22, 0, 0,   1, 2, 0, 64'h11, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 2, 1, 64'h33, 0, 0,   1, 2, 0, 64'h11, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 3, 1, 64'h44, 0, 0,   1, 2, 0, 64'h11, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 2, 0, 64'h55, 0, 0,   1, 2, 0, 64'h11, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 3, 0, 64'h66, 0, 0,   1, 2, 0, 64'h11, 1, 1, 2, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 64'h0,  0, 0,   1, 2, 0, 64'h11, 1, 0, 2, 1));
        vecs.push_back(mk(0, 1, 1, 3, 0, 64'h77, 0, 1,   1, 1, 0, 64'h22, 0, 0, 2, 1));
        vecs.push_back(mk(0, 0, 1, 2, 0, 64'h88, 0, 0,   1, 1, 0, 64'h22, 1, 1, 3, 1));
        vecs.push_back(mk(0, 0, 1, 2, 0, 64'h99, 0, 1,   1, 2, 1, 64'h33, 1, 0, 3, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 64'h0,  0, 1,   1, 3, 1, 64'h44, 1, 0, 3, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 64'h0,  0, 1,   1, 3, 0, 64'h77, 1, 0, 3, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 64'h0,  0, 1,   0, 0, 0, 64'h0,  1, 0, 3, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 64'h0,  0, 1,   0, 0, 0, 64'h0,  1, 0, 3, 0));
        vecs.push_back(mk(0, 0, 1, 3, 0, 64'hBB, 0, 1,   0, 0, 0, 64'h0,  1, 0, 3, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 64'h0,  0, 0,   0, 0, 0, 64'h0,  1, 0, 3, 1));
        vecs.push_back(mk(0, 1, 1, 2, 0, 64'h1,  1, 0,   1, 2, 0, 64'h1,  1, 0, 3, 1));
        vecs.push_back(mk(0, 1, 1, 3, 0, 64'h2,  0, 1,   1, 3, 0, 64'h2,  0, 0, 3, 1));

        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].vld, vecs[i].fmt, vecs[i].sub,
                 vecs[i].pay, vecs[i].rrst, vecs[i].rdy);
            check($sformatf("v%0d out_valid", i),   64'(ov),   64'(vecs[i].ov));
            check($sformatf("v%0d out_format", i),  64'(of),   64'(vecs[i].of));
            check($sformatf("v%0d out_subfmt", i),  64'(os),   64'(vecs[i].os));
            check($sformatf("v%0d out_payload", i), op,        vecs[i].op);
            check($sformatf("v%0d max_resync", i),  64'(mr),   64'(vecs[i].mr));
            check($sformatf("v%0d drop", i),        64'(drp),  64'(vecs[i].drp));
            check($sformatf("v%0d drop_cnt", i),    64'(dcnt), 64'(vecs[i].dcnt));
            check($sformatf("v%0d busy", i),        64'(busy), 64'(vecs[i].busy));
        end

        // Reset while three packets are buffered and drop_cnt is non-zero.
        step(0, 1, 1, 2, 0, 64'h3, 0, 0);
        step(0, 1, 1, 2, 0, 64'h4, 0, 0);
        check("pre_rst valid", 64'(ov), 64'd1);
        step(1, 1, 0, 0, 0, 64'h0, 0, 0);
        check("rst out_valid",   64'(ov),   64'd0);
        check("rst out_payload", op,        64'd0);
        check("rst drop_cnt",    64'(dcnt), 64'd0);
        check("rst max_resync",  64'(mr),   64'd0);
        check("rst busy",        64'(busy), 64'd0);

        // Resync counter: saturation, sync clear, and resync_rst clear.
        step(0, 1, 0, 0, 0, 64'h0, 0, 1);
        check("rs enable mr", 64'(mr), 64'd1);
        step(0, 1, 1, 3, 0, 64'h0, 0, 1);
        check("rs sync mr", 64'(mr), 64'd0);
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 1, 2, 0, 64'(i), 0, 1);
            check($sformatf("rs count%0d mr", i), 64'(mr), 64'(i == 16));
        end
        step(0, 1, 1, 2, 0, 64'h0, 0, 1);
        check("rs saturate mr", 64'(mr), 64'd1);
        step(0, 1, 1, 3, 0, 64'h0, 0, 1);
        check("rs resync clear mr", 64'(mr), 64'd0);
        for (int i = 1; i <= 10; i++) begin
            step(0, 1, 1, 2, 0, 64'(i), 0, 1);
            check($sformatf("rs pre%0d mr", i), 64'(mr), 64'd0);
        end
        step(0, 1, 0, 0, 0, 64'h0, 1, 1);
        check("rs rrst mr", 64'(mr), 64'd0);
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 1, 2, 0, 64'(i), 0, 1);
            check($sformatf("rs post%0d mr", i), 64'(mr), 64'(i == 16));
        end

        // Full FIFO with simultaneous pop each cycle: no drops, order kept.
        step(1, 0, 0, 0, 0, 64'h0, 0, 0);
        step(0, 1, 0, 0, 0, 64'h0, 0, 0);
        model.delete();
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 1, (k == 0) ? 2'd3 : 2'd2, 2'd0, 64'h100 + 64'(k), 0, 0);
            model.push_back(64'h100 + 64'(k));
        end
        check("fp full drop", 64'(drp), 64'd0);
        for (int k = 0; k < 8; k++) begin
            if (model.size() > 0) void'(model.pop_front());
            model.push_back(64'h200 + 64'(k));
            step(0, 1, 1, 2, 0, 64'h200 + 64'(k), 0, 1);
            check($sformatf("fp%0d drop", k),  64'(drp), 64'd0);
            check($sformatf("fp%0d head", k),  op,       model[0]);
        end
        check("fp drop_cnt", 64'(dcnt), 64'd0);
        for (int k = 0; k < 8 && model.size() > 0; k++) begin
            check($sformatf("fp drain%0d head", k), op, model[0]);
            void'(model.pop_front());
            step(0, 1, 0, 0, 0, 64'h0, 0, 1);
        end
        check("fp drained valid", 64'(ov), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/trdb_packet_scheduler.md
# trdb_packet_scheduler

Sequencing and buffering stage placed directly after `trdb_priority` in the trace encoder. It buffers the packet requests the priority block emits (format, subformat, payload) in a small FIFO and drains them to the packet encapsulator over a valid/ready handshake. It also owns the resync counter, driving `max_resync_o` back into the priority block's `tc_max_resync_i`. A forced-sync request is raised whenever the encoder is (re)enabled or a packet is lost to back-pressure.

## Interface
- `FIFO_DEPTH`, 4: packet slots; power of two, ≥2
- `PAYLOAD_W`, 64: width of packet payload carried alongside format/subformat
- `RESYNC_MAX`, 16: accepted non-sync packets before a resync is demanded; ≥2
- `clk_i` in 1: clock
- `rst_i` in 1: synchronous reset, active-high
- `enable_i` in 1: encoder enabled; level
- `pkt_valid_i` in 1: priority block has a packet this cycle (its `valid_o`)
- `packet_format_i` in 2: packet format
- `packet_f_sync_subformat_i` in 2: format-3 subformat
- `payload_i` in PAYLOAD_W: packet payload
- `resync_rst_i` in 1: priority block's resync-counter reset request
- `out_valid_o` out 1: FIFO head valid toward encapsulator
- `out_ready_i` in 1: encapsulator accepts head
- `out_format_o` out 2: head format
- `out_subformat_o` out 2: head subformat
- `out_payload_o` out PAYLOAD_W: head payload
- `max_resync_o` out 1: to priority `tc_max_resync_i`; next packet must be a sync
- `drop_o` out 1: one-cycle pulse, packet discarded
- `drop_cnt_o` out 16: saturating count of discarded packets
- `busy_o` out 1: FIFO non-empty or state ≠ IDLE

## Operation
- State machine: IDLE, RUN, DRAIN.
  - IDLE: input ignored; `enable_i`=1 moves to RUN and sets `force_sync`.
  - RUN: input accepted; `enable_i`=0 moves to DRAIN.
  - DRAIN: input ignored, FIFO keeps draining; empty moves to IDLE; `enable_i`=1 moves to RUN and sets `force_sync`.
- Sync packet means `packet_format_i`==3 and `packet_f_sync_subformat_i`==0.
- `pop` = `out_valid_o` & `out_ready_i`.
- A packet is accepted when state = RUN, `pkt_valid_i` = 1, and (FIFO not full or `pop`). Full with a simultaneous pop counts as space.
- A packet is dropped when state = RUN, `pkt_valid_i` = 1, FIFO full and no pop. Effects:
  - `drop_o` pulses the next cycle.
  - `drop_cnt_o` increments, saturating at 0xFFFF.
  - `force_sync` is set.
- Resync counter `rcnt` (width clog2(RESYNC_MAX+1)):
  - Cleared when a sync packet is accepted, or when `resync_rst_i`=1.
  - Otherwise increments on each accepted non-sync packet, saturating at RESYNC_MAX.
  - If a clear and an increment occur together, the clear wins.
- `force_sync` clears only when a sync packet is accepted. A drop in the same cycle does not apply, since a dropped packet is not accepted.
- `max_resync_o` = (`rcnt`==RESYNC_MAX) | `force_sync`.
- FIFO ordering is strict; packets are never reordered or merged. Read/write pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.

## Timing
- Reset values:
  - State IDLE, FIFO empty, `rcnt`=0, `force_sync`=0.
  - `out_valid_o`=0, `out_format_o`=0, `out_subformat_o`=0, `out_payload_o`=0.
  - `max_resync_o`=0, `drop_o`=0, `drop_cnt_o`=0, `busy_o`=0.
- Reset mid-operation discards all buffered packets. Outputs return to reset values on the cycle after `rst_i` is sampled high.
- Latency: a packet accepted at edge N appears at FIFO head with `out_valid_o`=1 after edge N, when the FIFO was empty. There is no combinational path from `pkt_valid_i` to `out_*`.
- Head outputs are stable while `out_valid_o`=1 and `out_ready_i`=0.
- Throughput: one accept and one pop per cycle sustained.
- `max_resync_o` is registered. It reflects accepts and clears from the previous edge, so the priority block sees it one cycle after the triggering event.
- The IDLE→RUN transition occurs on the edge where `enable_i`=1 is sampled. The first cycle in RUN already has `max_resync_o`=1.
- `out_ready_i` must not depend combinationally on `out_valid_o`.

## Test plan
- Enable after reset: `enable_i`=1 → next cycle `max_resync_o`=1. Push sync (3,0) with payload 0xA5 → `max_resync_o`=0 next cycle; `out_valid_o`=1, `out_format_o`=3, `out_payload_o`=0xA5.
- Resync count (RESYNC_MAX=16, `out_ready_i`=1): after sync, push 16 format-2 packets → `max_resync_o` rises the cycle after the 16th. Push sync → it falls. Assert `resync_rst_i` at count 10 → count returns to 0.
- Overflow (`out_ready_i`=0, FIFO_DEPTH=4): push 6 packets → 4 stored, `drop_o` pulses twice, `drop_cnt_o`=2, `max_resync_o`=1. Raise `out_ready_i` → the 4 originals drain in order.
- Full plus simultaneous pop: FIFO full, `out_ready_i`=1, `pkt_valid_i`=1 for 8 cycles → no drops; order preserved.
- Disable mid-stream: 3 buffered, `enable_i`=0 → DRAIN, new input ignored. FIFO empties, then IDLE with `busy_o`=0. Re-enable → `max_resync_o`=1.
- Reset with FIFO holding 3 packets → next cycle `out_valid_o`=0, `drop_cnt_o`=0, `max_resync_o`=0.
